neuron_mac_controller: RTL and testbench

Sequencer for one neuron of the layer datapath. Drives the 6-bit element offset into the input/weight selector. Accumulates the returned signed input × weight products over N elements, adds a bias, and applies optional right-shift, ReLU and clamp. Delivers the DW-bit activation over a valid/ready handshake to the next layer stage.

---
 rtl/neuron_mac_controller.sv | 124 ++++++++++++
 tb/tb_neuron_mac_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_controller.sv
// Per-neuron sequencer: steps the selector offset, accumulates signed
// input*weight products, adds bias, then shifts, applies ReLU and clamps.
// Ports: clk, rst_n (async low); start/busy request control;
//        offset -> selector, sel_inp/sel_weight <- selector; bias in;
//        out_data/out_valid/out_ready result handshake.
module neuron_mac_controller #(
    parameter int N     = 10,
    parameter int DW    = 8,
    parameter int ACC_W = 20,
    parameter int SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic [5:0]    offset,
    input  logic [DW-1:0] sel_inp,
    input  logic [DW-1:0] sel_weight,
    input  logic [DW-1:0] bias,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_BIAS = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [5:0] LAST  = 6'(N - 1);
    localparam int         SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((1 << (DW - 1)) - 1);

    logic [1:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [5:0]              offset_q, offset_d;
    logic [DW-1:0]           data_q, data_d;
    logic                    valid_q, valid_d;

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shr;
    logic [DW-1:0]           act;

    assign prod     = $signed(sel_inp) * $signed(sel_weight);
    assign prod_ext = {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};

    // One spare bit keeps acc+bias exact before the shift.
    assign sum = {{(SUM_W - ACC_W){acc_q[ACC_W-1]}}, acc_q}
               + {{(SUM_W - DW){bias[DW-1]}}, bias};
    assign shr = sum >>> SHIFT;

    always_comb begin
        act = '0;
        if (shr[SUM_W-1]) begin
            act = '0;
        end else if (shr > MAXV) begin
            act = MAXV[DW-1:0];
        end else begin
            act = shr[DW-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        offset_d = offset_q;
        data_d   = data_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    offset_d = '0;
                    state_d  = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                if (offset_q == LAST) begin
                    offset_d = '0;
                    state_d  = S_BIAS;
                end else begin
                    offset_d = offset_q + 6'd1;
                end
            end
            S_BIAS: begin
                data_d  = act;
                valid_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            offset_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            offset_q <= offset_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign offset    = offset_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_neuron_mac_controller.sv
// Directed bench for neuron_mac_controller: default instance plus a
// SHIFT=2 instance, each fed by a table-driven selector model.
module tb_neuron_mac_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start0 = 1'b0, start1 = 1'b0;
    logic       busy0, busy1;
    logic [5:0] off0, off1;
    logic [7:0] inp0 [64];
    logic [7:0] wt0 [64];
    logic [7:0] inp1 [64];
    logic [7:0] wt1 [64];
    logic [7:0] bias0 = '0, bias1 = '0;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0 = 1'b1, ready1 = 1'b1;

    int checks = 0;
    int errors = 0;

    neuron_mac_controller u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0),
        .offset(off0), .sel_inp(inp0[off0]), .sel_weight(wt0[off0]),
        .bias(bias0), .out_data(data0), .out_valid(valid0),
        .out_ready(ready0)
    );

    neuron_mac_controller #(.SHIFT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
        .offset(off1), .sel_inp(inp1[off1]), .sel_weight(wt1[off1]),
        .bias(bias1), .out_data(data1), .out_valid(valid1),
        .out_ready(ready1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill0(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 64; i++) begin
            inp0[i] = a;
            wt0[i]  = b;
        end
    endtask

    // Pulse start, walk MAC, check BIAS cycle and the result.
    task automatic run0(input string tag, input logic [7:0] exp,
                        input bit chk_off);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        chk({tag, "_busy"}, 32'(busy0), 32'd1);
        chk({tag, "_off0"}, 32'(off0), 32'd0);
        for (int k = 1; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (chk_off) chk({tag, "_off"}, 32'(off0), 32'(k));
        end
        @(posedge clk);
        #1;
        chk({tag, "_bias_valid"}, 32'(valid0), 32'd0);
        chk({tag, "_bias_off"}, 32'(off0), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 32'(valid0), 32'd1);
        chk({tag, "_data"}, 32'(data0), 32'(exp));
    endtask

    task automatic finish0(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_idle_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_idle_valid"}, 32'(valid0), 32'd0);
    endtask

    initial begin
        fill0(8'd0, 8'd0);
        for (int i = 0; i < 64; i++) begin
            inp1[i] = 8'd0;
            wt1[i]  = 8'd0;
        end
        #12;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_off", 32'(off0), 32'd0);
        chk("rst_data", 32'(data0), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 10 * (1*2) + 3
        fill0(8'd1, 8'd2);
        bias0 = 8'd3;
        run0("basic", 8'd23, 1'b1);
        finish0("basic");

        // 10 * (5*-1) = -50 -> ReLU
        fill0(8'd5, 8'hFF);
        bias0 = 8'd0;
        run0("relu", 8'd0, 1'b0);
        finish0("relu");

        // 10 * 10000 = 100000 -> clamp
        fill0(8'd100, 8'd100);
        run0("clamp", 8'd127, 1'b0);
        finish0("clamp");

        // in[i]=i, w = 2 on odd, -1 on even: 50 - 20 + 10 = 40
        fill0(8'd0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            inp0[i] = 8'(i);
            wt0[i]  = (i % 2 == 1) ? 8'd2 : 8'hFF;
        end
        bias0 = 8'd10;
        run0("ramp", 8'd40, 1'b0);
        finish0("ramp");

        // Backpressure with ignored start pulses
        fill0(8'd1, 8'd2);
        bias0 = 8'd3;
        ready0 = 1'b0;
        run0("bp", 8'd23, 1'b0);
        for (int k = 0; k < 5; k++) begin
            start0 = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(valid0), 32'd1);
            chk("bp_hold_data", 32'(data0), 32'd23);
            chk("bp_hold_busy", 32'(busy0), 32'd1);
        end
        ready0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        chk("bp_hs_busy", 32'(busy0), 32'd0);
        chk("bp_hs_valid", 32'(valid0), 32'd0);
        @(posedge clk);
        #1;
        chk("bp_start_ignored", 32'(busy0), 32'd0);
        chk("bp_data_hold", 32'(data0), 32'd23);

        // Abort mid-MAC
        fill0(8'd7, 8'd7);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_off4", 32'(off0), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(valid0), 32'd0);
        chk("abort_off", 32'(off0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        fill0(8'd1, 8'd2);
        run0("after_rst", 8'd23, 1'b0);
        finish0("after_rst");

        // SHIFT=2: (90 - 2) >>> 2 = 22
        for (int i = 0; i < 64; i++) begin
            inp1[i] = 8'd3;
            wt1[i]  = 8'd3;
        end
        bias1 = 8'hFE;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("sh2_bias_valid", 32'(valid1), 32'd0);
        @(posedge clk);
        #1;
        chk("sh2_valid", 32'(valid1), 32'd1);
        chk("sh2_data", 32'(data1), 32'd22);
        @(posedge clk);
        #1;
        chk("sh2_idle", 32'(busy1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
